alu_mult_seq: RTL and testbench

Multi-cycle unsigned multiply sequencer that drives the shared 32-bit ALU's operand, control and shift-amount inputs to compute the low 32 bits of A×B by shift-and-add. It sits beside the ALU in the datapath and owns the ALU ports while busy. The rest of the core must not drive the ALU during that time. It uses only the ALU's add, lsl, lsr and or operations and its zero flag.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mult_seq.sv | 145 ++++++++++++++
 tb/tb_alu_mult_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the multiply-sequencer state type.
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_NOT = 4'b0010;
    localparam logic [3:0] ALU_LSL = 4'b0011;
    localparam logic [3:0] ALU_LSR = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam int unsigned  MULT_ITERS     = 32;
    localparam logic [5:0]   MULT_ITER_LAST = 6'd32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TEST = 3'd1,
        ST_ADD  = 3'd2,
        ST_SHL  = 3'd3,
        ST_SHR  = 3'd4,
        ST_DONE = 3'd5
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_mult_seq.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU for every
// arithmetic step; returns the low 32 bits of op_a*op_b.
`default_nettype none

module alu_mult_seq
    import alu_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_out,
    input  logic        alu_zero
);

    seq_state_e  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] m_q, m_d;
    logic [31:0] q_q, q_d;
    logic [5:0]  iter_q, iter_d;
    logic [31:0] product_q, product_d;
    logic        w_exit;

    // The TEST step ORs q with zero, so alu_zero reports "no multiplier bits left".
    assign w_exit = (EARLY_EXIT && alu_zero) || (iter_q == MULT_ITER_LAST);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        iter_d    = iter_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = op_a;
                    q_d     = op_b;
                    acc_d   = 32'd0;
                    iter_d  = 6'd0;
                    state_d = ST_TEST;
                end
            end
            ST_TEST: begin
                if (w_exit) begin
                    // Loaded on the edge into DONE so product never glitches mid-run.
                    product_d = acc_q;
                    state_d   = ST_DONE;
                end else if (q_q[0]) begin
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_SHL;
                end
            end
            ST_ADD: begin
                acc_d   = alu_out;
                state_d = ST_SHL;
            end
            ST_SHL: begin
                m_d     = alu_out;
                state_d = ST_SHR;
            end
            ST_SHR: begin
                q_d     = alu_out;
                iter_d  = iter_q + 6'd1;
                state_d = ST_TEST;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_ctrl  = ALU_ADD;
        alu_shamt = 5'd0;
        case (state_q)
            ST_TEST: begin
                alu_a    = q_q;
                alu_ctrl = ALU_OR;
            end
            ST_ADD: begin
                alu_a    = acc_q;
                alu_b    = m_q;
                alu_ctrl = ALU_ADD;
            end
            ST_SHL: begin
                alu_a     = m_q;
                alu_ctrl  = ALU_LSL;
                alu_shamt = 5'd1;
            end
            ST_SHR: begin
                alu_a     = q_q;
                alu_ctrl  = ALU_LSR;
                alu_shamt = 5'd1;
            end
            default: begin
                alu_a     = 32'd0;
                alu_b     = 32'd0;
                alu_ctrl  = ALU_ADD;
                alu_shamt = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= 32'd0;
            m_q       <= 32'd0;
            q_q       <= 32'd0;
            iter_q    <= 6'd0;
            product_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            iter_q    <= iter_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mult_seq.sv
// Drives an early-exit and a fixed-latency sequencer, each attached to a behavioural ALU.
`default_nettype none

module tb_alu_mult_seq;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start    [2];
    logic [31:0] opa      [2];
    logic [31:0] opb      [2];
    logic        busy     [2];
    logic        done     [2];
    logic [31:0] prod     [2];
    logic [31:0] aa       [2];
    logic [31:0] ab       [2];
    logic [3:0]  actl     [2];
    logic [4:0]  ash      [2];
    logic [31:0] aout     [2];
    logic        azero    [2];
    logic [31:0] exp_prod [2];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c, input logic [4:0] s);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_NOT: return ~a;
            ALU_LSL: return a << s;
            ALU_LSR: return a >> s;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
            default: return 32'd0;
        endcase
    endfunction

    assign aout[0]  = alu_ref(aa[0], ab[0], actl[0], ash[0]);
    assign aout[1]  = alu_ref(aa[1], ab[1], actl[1], ash[1]);
    assign azero[0] = (aout[0] == 32'd0);
    assign azero[1] = (aout[1] == 32'd0);

    alu_mult_seq #(.EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .op_a(opa[0]), .op_b(opb[0]),
        .busy(busy[0]), .done(done[0]), .product(prod[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_ctrl(actl[0]), .alu_shamt(ash[0]),
        .alu_out(aout[0]), .alu_zero(azero[0])
    );

    alu_mult_seq #(.EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .op_a(opa[1]), .op_b(opb[1]),
        .busy(busy[1]), .done(done[1]), .product(prod[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_ctrl(actl[1]), .alu_shamt(ash[1]),
        .alu_out(aout[1]), .alu_zero(azero[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int md, input string tag);
        check($sformatf("%s.busy%0d", tag, md),  {31'd0, busy[md]}, 32'd0);
        check($sformatf("%s.done%0d", tag, md),  {31'd0, done[md]}, 32'd0);
        check($sformatf("%s.alu_a%0d", tag, md), aa[md], 32'd0);
        check($sformatf("%s.alu_b%0d", tag, md), ab[md], 32'd0);
        check($sformatf("%s.ctrl%0d", tag, md),  {28'd0, actl[md]}, {28'd0, ALU_ADD});
        check($sformatf("%s.shamt%0d", tag, md), {27'd0, ash[md]}, 32'd0);
    endtask

    // Called at a falling edge; start is sampled on the next rising edge (edge 0).
    task automatic run_op(input int md, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        logic [31:0] want, old;
        logic [3:0]  trace[$];
        logic [3:0]  exp_tr[$];
        int n, p, iters, exp_cyc, dcyc;
        string tag;
        tag  = $sformatf("m%0d %h*%h", md, a, b);
        old  = exp_prod[md];
        want = a * b;
        n = 0;
        p = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) begin
                n = i + 1;
                p++;
            end
        end
        exp_cyc = (md == 0) ? 3 * n + p + 2 : 98 + p;
        iters   = (md == 0) ? n : 32;
        for (int it = 0; it < iters; it++) begin
            exp_tr.push_back(ALU_OR);
            if (b[it]) exp_tr.push_back(ALU_ADD);
            exp_tr.push_back(ALU_LSL);
            exp_tr.push_back(ALU_LSR);
        end
        exp_tr.push_back(ALU_OR);

        start[md] = 1'b1;
        opa[md]   = a;
        opb[md]   = b;
        @(posedge clk);
        #1 start[md] = 1'b0;
        dcyc = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done[md] === 1'b1) dcyc = k;
            else trace.push_back(actl[md]);
            check({tag, " busy"}, {31'd0, busy[md]}, 32'd1);
            check({tag, " product"}, prod[md], (dcyc > 0) ? want : old);
            if (poke) begin
                if (k == 3 || dcyc > 0) begin
                    start[md] = 1'b1;
                    opa[md]   = 32'hDEAD_BEEF;
                    opb[md]   = 32'h0000_00FF;
                end else begin
                    start[md] = 1'b0;
                end
            end
            if (dcyc > 0) break;
        end
        check({tag, " done_cycle"}, dcyc, exp_cyc);
        check({tag, " trace_len"}, trace.size(), exp_tr.size());
        if (trace.size() == exp_tr.size()) begin
            for (int i = 0; i < trace.size(); i++) begin
                check($sformatf("%s ctrl[%0d]", tag, i), {28'd0, trace[i]}, {28'd0, exp_tr[i]});
            end
        end
        @(negedge clk);
        start[md] = 1'b0;
        check({tag, " busy_fall"}, {31'd0, busy[md]}, 32'd0);
        check({tag, " done_fall"}, {31'd0, done[md]}, 32'd0);
        check({tag, " held"}, prod[md], want);
        if (poke) begin
            @(negedge clk);
            check({tag, " ignored_busy"}, {31'd0, busy[md]}, 32'd0);
            check({tag, " ignored_prod"}, prod[md], want);
        end
        exp_prod[md] = want;
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d]    = 1'b0;
            opa[d]      = 32'd0;
            opb[d]      = 32'd0;
            exp_prod[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle(d, "reset");
            check($sformatf("reset.product%0d", d), prod[d], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 32'h0000_1234, 32'h0, 1'b0);
        run_op(0, 32'd6, 32'd7, 1'b0);
        run_op(1, 32'd6, 32'd7, 1'b0);
        run_op(0, 32'h8000_0001, 32'h0000_0003, 1'b0);
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(0, 32'd9, 32'd11, 1'b1);
        run_op(1, 32'd13, 32'd10, 1'b1);
        run_op(0, 32'd5, 32'd5, 1'b0);
        run_op(0, 32'd2, 32'd3, 1'b0);
        check_idle(0, "after_b2b");

        for (int r = 0; r < 8; r++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(0, ra, rb, 1'b0);
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(1, ra, rb, 1'b0);
        end

        // Abort a long multiply partway through.
        start[0] = 1'b1;
        opa[0]   = 32'd7;
        opb[0]   = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("midrun.busy_before", {31'd0, busy[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_idle(d, "midrun");
            check($sformatf("midrun.product%0d", d), prod[d], 32'd0);
            exp_prod[d] = 32'd0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 32'd3, 32'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
